// File: rtl/led_pixel_fifo.sv
// -----------------------------------------------------------------------------
// led_pixel_fifo
//
// Pixel buffer and frame trigger in front of the LED serial sender. 24-bit RGB
// words are stored in a small register FIFO. The head word is presented
// first-word-fall-through on data_out and advances on the sender's rd pulse.
// Once a full frame (LED_NUM words) is buffered, a one-cycle enable starts a
// sender transaction. Re-triggering is then held off for HOLD_CNT clocks.
//
// Ports
//   clk        system clock, shared with the sender
//   rstn       synchronous active-low reset
//   wr_en      write strobe from the pixel source
//   wr_data    pixel word {B, G, R}
//   full       level == DEPTH
//   rd         read pulse from the sender; pops the head word
//   data_out   head word, 0 when empty
//   empty      level == 0
//   level      number of words stored
//   enable     one-cycle frame-start pulse
//   clr_err    clears the sticky error flags
//   overflow   sticky: a write was dropped
//   underflow  sticky: a read hit an empty FIFO
// -----------------------------------------------------------------------------
module led_pixel_fifo #(
   parameter int LED_NUM  = 4,
   parameter int DEPTH    = 16,
   parameter int HOLD_CNT = 2048
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     wr_en,
   input  logic [23:0]              wr_data,
   output logic                     full,
   input  logic                     rd,
   output logic [23:0]              data_out,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     enable,
   input  logic                     clr_err,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int HW = $clog2(HOLD_CNT + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FIRE = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   logic [23:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic [1:0]    state_q, state_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;

   logic          full_w;
   logic          empty_w;
   logic          wr_ok;
   logic          rd_ok;

   // Hold counter increment that sticks at HOLD_CNT instead of wrapping.
   function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
      if (v == HW'(HOLD_CNT)) begin
         return v;
      end
      return v + HW'(1);
   endfunction

   // FIFO control
   always_comb begin
      full_w   = (level_q == LW'(DEPTH));
      empty_w  = (level_q == '0);
      // A write into a full FIFO is still taken when the head leaves this cycle.
      wr_ok    = wr_en && (!full_w || rd);
      rd_ok    = rd && !empty_w;

      wr_ptr_d = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;

      level_d = level_q;
      case ({wr_ok, rd_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // A fresh error outranks a simultaneous clear.
      overflow_d  = (overflow_q && !clr_err) || (wr_en && !wr_ok);
      underflow_d = (underflow_q && !clr_err) || (rd && empty_w);
   end

   // Frame trigger FSM
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (level_q >= LW'(LED_NUM)) begin
               state_d = ST_FIRE;
            end
         end
         ST_FIRE: begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
         end
         ST_HOLD: begin
            hold_cnt_d = sat_inc(hold_cnt_q);
            if (hold_cnt_q == HW'(HOLD_CNT - 1)) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         state_q     <= ST_IDLE;
         hold_cnt_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   // Pixel storage carries no reset; stale words are unreachable once the
   // pointers and level are cleared.
   always_ff @(posedge clk) begin
      if (rstn && wr_ok) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign full      = full_w;
   assign empty     = empty_w;
   assign level     = level_q;
   assign data_out  = empty_w ? 24'h000000 : mem_q[rd_ptr_q];
   assign enable    = (state_q == ST_FIRE);
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: doc/led_pixel_fifo.md
# led_pixel_fifo

Pixel buffer and frame trigger that sits directly upstream of the LED serial sender. It stores 24-bit RGB pixel words from the pixel source and presents the head word first-word-fall-through on the sender's data input. It advances on the sender's one-cycle read pulse. When a full frame of `LED_NUM` pixels is buffered, it issues the one-cycle `enable` that starts a sender transaction, then holds off re-triggering until that transaction is over.

## Interface
Parameters:
- `LED_NUM`, 4 — pixels per frame; `enable` fires only when at least this many words are buffered; range 1..DEPTH.
- `DEPTH`, 16 — FIFO depth in 24-bit words; power of two, ≥ 2.
- `HOLD_CNT`, 2048 — clocks in HOLD after each `enable`; must exceed the sender's worst-case transaction length in clocks; ≥ 1.

Ports:
- `clk`  in  1  — system clock, 150 MHz, shared with the sender.
- `rstn`  in  1  — reset, synchronous, active-low.
- `wr_en`  in  1  — write strobe from the pixel source.
- `wr_data`  in  24  — pixel word {B[7:0], G[7:0], R[7:0]}.
- `full`  out  1  — `level == DEPTH`.
- `rd`  in  1  — read pulse from the sender; pops the head word.
- `data_out`  out  24  — head word, connected to the sender's pixel input; 24'h000000 when empty.
- `empty`  out  1  — `level == 0`.
- `level`  out  $clog2(DEPTH)+1  — words stored.
- `enable`  out  1  — one-cycle frame-start pulse to the sender.
- `clr_err`  in  1  — clears the sticky error flags.
- `overflow`  out  1  — sticky: a write was dropped.
- `underflow`  out  1  — sticky: a read hit an empty FIFO.

## Operation
- Storage: register array `DEPTH`×24, with write pointer and read pointer each $clog2(DEPTH) bits. Pointers wrap naturally modulo `DEPTH`.
- `level` is tracked in a separate counter, not derived from the pointers.
- `data_out` = `mem[rd_ptr]` when `!empty`, otherwise 0. It is combinational from registers, with no added read latency.
- Write is accepted when `wr_en && (!full || rd)`.
- Read is accepted when `rd && !empty`.
- Full with `wr_en && rd`: both are accepted and `level` is unchanged.
- Full with `wr_en` and no `rd`: the word is dropped and `overflow` sets.
- Empty with `rd`: the read is ignored and `underflow` sets. This holds even when `wr_en` is also high; the write is still accepted.
- `level` update: +1 on a write alone, −1 on a read alone, unchanged on both or neither.
- Sticky flags: `clr_err` clears them; a new error in the same cycle as `clr_err` wins, so the flag stays set.
- Frame FSM, states IDLE → FIRE → HOLD → IDLE:
  - IDLE: moves to FIRE when `level >= LED_NUM`.
  - FIRE: lasts one cycle with `enable` = 1, then moves to HOLD and loads the hold counter with 0.
  - HOLD: the counter increments each clock. At `HOLD_CNT-1` the FSM returns to IDLE. `level` is ignored in HOLD.
  - `enable` = (state == FIRE), decoded from a registered state.
  - The hold counter is $clog2(HOLD_CNT+1) bits and saturates; it never wraps.
- Writes and reads continue in every FSM state.
- An unused state encoding returns to IDLE on the next clock.

## Timing
- Reset, sampled on `clk` with `rstn` = 0, sets:
  - pointers and `level` = 0;
  - `empty` = 1, `full` = 0;
  - `data_out` = 0, `enable` = 0;
  - `overflow` = 0, `underflow` = 0;
  - FSM in IDLE, hold counter = 0.
- Memory contents are not reset. A reset in the middle of a frame discards all buffered words.
- Write to visible: a word written at edge N appears on `data_out` after edge N when the FIFO was empty (`empty` falls after edge N).
- Pop: `rd` at edge N makes the next word visible after edge N.
- Status outputs `full`, `empty` and `level` are registered/derived from registers and update after the same edge as the access that changes them.
- Trigger: if `level` reaches `LED_NUM` after edge N, FSM enters FIRE after edge N+1, so `enable` is high for the cycle between edges N+1 and N+2.
- HOLD spans exactly `HOLD_CNT` cycles. The earliest next `enable` is `HOLD_CNT`+2 cycles after the previous one.
- `rd` from the sender is a single-cycle pulse; back-to-back `rd` in consecutive cycles must also work (one pop per cycle).

## Test plan
- Reset, then write 3 words with `LED_NUM` = 4 → `enable` stays 0 and `level` = 3. A 4th write (24'h0000FF) → exactly one `enable` pulse, 2 cycles after that write's edge.
- Write 24'h112233, 24'h445566, then pulse `rd` → `data_out` shows 24'h112233 before the pop and 24'h445566 after it, with `level` going 2 → 1.
- Fill to 16 words, then write with no `rd` → `full` = 1, word dropped, `level` = 16, `overflow` = 1. Next, `wr_en` and `rd` together → `level` stays 16 and the new word lands at the tail.
- `rd` when empty → `underflow` = 1, `level` = 0, `data_out` = 0. `clr_err` → 0. `rd` and `clr_err` together on empty → `underflow` stays 1.
- `HOLD_CNT` = 8, keep `level` ≥ 4 throughout → `enable` pulses every 10 cycles. A write of 8 words after reset → no second pulse inside HOLD.
- 20 words written and read with pointer wrap past `DEPTH` → output order matches input order. Assert `rstn` = 0 mid-stream → all outputs at reset values on the next cycle.
